// File: rtl/cpix_pack.sv
// rtl/cpix_pack.sv - pixel-pair to bitplane-packed 8-pixel tile row packer
module cpix_pack #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       pa,
    input  logic [3:0]       pb,
    input  logic             h,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             out_blank,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        FILL3 = 2'd3
    } beat_e;

    beat_e             beat_q, beat_d;
    logic [31:0]       asm_q, asm_d;
    logic              h_q, h_d;
    logic              asm_full_q, asm_full_d;
    logic              flush_pend_q, flush_pend_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_word_q, out_word_d;
    logic              out_blank_q, out_blank_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic              out_free;
    logic              h_eff;
    logic [2:0]        idx_a;
    logic [2:0]        idx_b;
    logic [31:0]       new_word;
    logic              word_done;
    logic [31:0]       done_word;

    // Beat assembly, word completion/flush, output register hand-off and word counting
    always_comb begin
        beat_d       = beat_q;
        asm_d        = asm_q;
        h_d          = h_q;
        asm_full_d   = asm_full_q;
        flush_pend_d = flush_pend_q;
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        cnt_d        = cnt_q;

        // Stall only when a finished word waits behind a blocked output register
        in_ready = !(asm_full_q && out_valid_q && !out_ready);
        accept   = in_valid && in_ready;
        out_free = !out_valid_q || out_ready;

        // The flip flag of a word is taken from its first beat only
        h_eff = (beat_q == EMPTY) ? h : h_q;
        idx_a = h_eff ? (3'd7 - {beat_q, 1'b0}) : {beat_q, 1'b0};
        idx_b = h_eff ? (3'd7 - {beat_q, 1'b1}) : {beat_q, 1'b1};

        // Starting a new word clears the assembly so unfilled pixels stay transparent
        new_word = (beat_q == EMPTY) ? 32'd0 : asm_q;
        for (int j = 0; j < 4; j++) begin
            new_word[8*j + int'(idx_a)] = pa[j];
            new_word[8*j + int'(idx_b)] = pb[j];
        end

        word_done = accept ? ((beat_q == FILL3) || flush)
                           : (flush && (beat_q != EMPTY));
        done_word = accept ? new_word : asm_q;

        if (out_valid_q && out_ready) begin
            cnt_d       = cnt_q + CNT_W'(1);
            out_valid_d = 1'b0;
        end

        // A held complete word moves out first, freeing the assembly for new data
        if (asm_full_q && out_free) begin
            out_valid_d  = 1'b1;
            out_word_d   = asm_q;
            asm_full_d   = 1'b0;
            flush_pend_d = 1'b0;
        end

        if (accept) begin
            asm_d  = new_word;
            beat_d = beat_e'(2'(beat_q + 2'd1));
            if (beat_q == EMPTY) begin
                h_d = h;
            end
        end

        if (word_done) begin
            beat_d = EMPTY;
            if (out_free && !asm_full_q) begin
                out_valid_d = 1'b1;
                out_word_d  = done_word;
            end else begin
                asm_full_d   = 1'b1;
                asm_d        = done_word;
                flush_pend_d = flush && !(accept && (beat_q == FILL3));
            end
        end

        out_blank_d = (out_word_d == 32'd0);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q       <= EMPTY;
            asm_q        <= 32'd0;
            h_q          <= 1'b0;
            asm_full_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_word_q   <= 32'd0;
            out_blank_q  <= 1'b1;
            cnt_q        <= '0;
        end else begin
            beat_q       <= beat_d;
            asm_q        <= asm_d;
            h_q          <= h_d;
            asm_full_q   <= asm_full_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            out_blank_q  <= out_blank_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_blank = out_blank_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_cpix_pack.sv
// tb/tb_cpix_pack.sv - randomized and directed self-checking bench for cpix_pack
module tb_cpix_pack;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    pa;
    logic [3:0]    pb;
    logic          h;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_word;
    logic          out_blank;
    logic [CW-1:0] word_cnt;

    int checks = 0;
    int errors = 0;

    cpix_pack #(.CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pa        (pa),
        .pb        (pb),
        .h         (h),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_blank (out_blank),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference packing: pixel p, plane j lands at bit 8*j + p (or 7-p when flipped)
    function automatic logic [31:0] pack(input logic [7:0][3:0] px, input logic hf);
        logic [31:0] w;
        w = 32'd0;
        for (int p = 0; p < 8; p++)
            for (int j = 0; j < 4; j++)
                w[8*j + (hf ? 7 - p : p)] = px[p][j];
        return w;
    endfunction

    // Inputs as seen by the DUT at each rising edge
    logic          s_reset = 1'b1;
    logic          s_iv = 1'b0;
    logic          s_fl = 1'b0;
    logic          s_h = 1'b0;
    logic          s_ordy = 1'b0;
    logic [3:0]    s_pa = 4'd0;
    logic [3:0]    s_pb = 4'd0;

    always @(posedge clk) begin
        s_reset <= reset;
        s_iv    <= in_valid;
        s_fl    <= flush;
        s_h     <= h;
        s_ordy  <= out_ready;
        s_pa    <= pa;
        s_pb    <= pb;
    end

    // Behavioural model: words queued in order, pixels collected in an array
    logic [31:0]     mq[$];
    logic [7:0][3:0] mpix;
    int              mbeats;
    logic            mh;
    logic [CW-1:0]   mcnt;
    logic            m_rdy;
    logic            m_acc;

    initial begin
        mpix   = '0;
        mbeats = 0;
        mh     = 1'b0;
        mcnt   = '0;
    end

    always @(negedge clk) begin
        if (s_reset) begin
            mq.delete();
            mbeats = 0;
            mh     = 1'b0;
            mcnt   = '0;
        end else begin
            m_rdy = !(mq.size() == 2 && !s_ordy);
            if (mq.size() > 0 && s_ordy) begin
                void'(mq.pop_front());
                mcnt = mcnt + 1'b1;
            end
            m_acc = s_iv && m_rdy;
            if (m_acc) begin
                if (mbeats == 0) begin
                    mpix = '0;
                    mh   = s_h;
                end
                mpix[2*mbeats]     = s_pa;
                mpix[2*mbeats + 1] = s_pb;
                mbeats++;
            end
            if (mbeats == 4 || (s_fl && mbeats > 0)) begin
                mq.push_back(pack(mpix, mh));
                mbeats = 0;
            end
        end
        chk("in_ready", 32'(in_ready), 32'(!(mq.size() == 2 && !out_ready)));
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("word_cnt", 32'(word_cnt), 32'(mcnt));
        if (mq.size() > 0) begin
            chk("out_word", out_word, mq[0]);
            chk("out_blank", 32'(out_blank), 32'(mq[0] == 32'd0));
        end
    end

    task automatic step(input logic iv, input logic [3:0] a, input logic [3:0] b,
                        input logic hh, input logic fl, input logic ordy);
        @(negedge clk);
        #2;
        in_valid  = iv;
        pa        = a;
        pb        = b;
        h         = hh;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n, input logic ordy);
        repeat (n) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, ordy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic word_1_8(input logic h0, input logic ordy);
        step(1'b1, 4'd1, 4'd2, h0,   1'b0, ordy);
        step(1'b1, 4'd3, 4'd4, 1'b0, 1'b0, ordy);
        step(1'b1, 4'd5, 4'd6, 1'b0, 1'b0, ordy);
        step(1'b1, 4'd7, 4'd8, 1'b0, 1'b0, ordy);
    endtask

    logic [7:0][3:0] lit_px;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        pa        = 4'd0;
        pb        = 4'd0;
        h         = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        lit_px = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        chk("model_pack_h0", pack(lit_px, 1'b0), 32'h80786655);
        chk("model_pack_h1", pack(lit_px, 1'b1), 32'h011E66AA);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_out_blank", 32'(out_blank), 32'd1);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Plain word, one-cycle latency
        word_1_8(1'b0, 1'b1);
        chk("s33_valid", 32'(out_valid), 32'd1);
        chk("s33_word", out_word, 32'h80786655);
        idle(1, 1'b1);
        chk("s33_cnt", 32'(word_cnt), 32'd1);

        // Flip latched on beat 0 only
        word_1_8(1'b1, 1'b1);
        chk("s34_word", out_word, 32'h011E66AA);
        idle(1, 1'b1);

        // Backpressure holds two words
        word_1_8(1'b0, 1'b0);
        word_1_8(1'b0, 1'b0);
        chk("s35_in_ready", 32'(in_ready), 32'd0);
        chk("s35_word", out_word, 32'h80786655);
        idle(2, 1'b0);
        chk("s35_hold", out_word, 32'h80786655);
        idle(1, 1'b1);
        chk("s35_second_valid", 32'(out_valid), 32'd1);
        idle(1, 1'b1);
        chk("s35_drained", 32'(out_valid), 32'd0);
        chk("s35_cnt", 32'(word_cnt), 32'd4);

        // Flush padding and blank detection
        step(1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        chk("s36_word", out_word, 32'h0F0F0F0F);
        chk("s36_blank0", 32'(out_blank), 32'd0);
        idle(1, 1'b1);
        step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        chk("s36_blank1", 32'(out_blank), 32'd1);
        idle(1, 1'b1);
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        chk("flush_empty_ignored", 32'(out_valid), 32'd0);

        // Reset mid-word discards the partial word
        do_reset();
        step(1'b1, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1);
        do_reset();
        chk("s37_in_ready", 32'(in_ready), 32'd1);
        word_1_8(1'b0, 1'b1);
        chk("s37_word", out_word, 32'h80786655);
        idle(1, 1'b1);
        chk("s37_cnt", 32'(word_cnt), 32'd1);

        // Counter wrap after 2^CW handoffs
        do_reset();
        repeat (16) step(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);
        chk("s38_wrap", 32'(word_cnt), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #2;
            reset     = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 9) < 6);
            pa        = 4'($urandom);
            pb        = 4'($urandom);
            h         = 1'($urandom);
            flush     = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpix_pack.md
CPIX_PACK -- requirements
Module: cpix_pack

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the emitted-word counter.
REQ-002 SHALL have port clk, input, 1, the single clock (12 MHz pixel clock domain); all logic updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid, input, 1, a pixel-pair beat is offered.
REQ-005 SHALL have port in_ready, output, 1, the block accepts the beat this cycle.
REQ-006 SHALL have port pa, input, 4, colour index of the even (left) pixel of the pair.
REQ-007 SHALL have port pb, input, 4, colour index of the odd (right) pixel of the pair.
REQ-008 SHALL have port h, input, 1, horizontal-flip flag, sampled on the first beat of each word.
REQ-009 SHALL have port flush, input, 1, pad the partial word with transparent pixels and emit it.
REQ-010 SHALL have port out_valid, output, 1, out_word is valid.
REQ-011 SHALL have port out_ready, input, 1, the consumer takes out_word this cycle.
REQ-012 SHALL have port out_word, output, 32, bitplane-packed 8-pixel tile row.
REQ-013 SHALL have port out_blank, output, 1, out_word has all 8 pixels transparent (out_word == 0).
REQ-014 SHALL have port word_cnt, output, CNT_W, count of words handed off.

Function
REQ-015 SHALL accept a beat when in_valid && in_ready are both high; beat k (0..3) of a word carries pixels 2k (pa) and 2k+1 (pb).
REQ-016 SHALL pack without flip as follows: pixel p, plane bit j (j=0..3) goes to out_word[8*j+p].
REQ-017 SHALL pack with the latched h=1 as follows: pixel p, plane bit j goes to out_word[8*j+(7-p)].
REQ-018 SHALL latch h only on beat 0; h changes during beats 1..3 SHALL have no effect on that word.
REQ-019 SHALL keep a 2-bit beat counter in an assembly register (states EMPTY, FILL1..FILL3); the counter SHALL wrap 3->0 when beat 3 is accepted.
REQ-020 SHALL use a one-word output register and so hold at most two words in total (assembly plus output).
REQ-021 SHALL drive in_ready = !(asm_full && out_valid && !out_ready); asm_full is set in the cycle beat 3 is taken while the output register is occupied.
REQ-022 SHALL transfer the completed word to the output register, with out_valid high, on the cycle after beat 3 when the output register is empty or being drained; the latency from beat 3 to out_valid is 1 cycle.
REQ-023 SHALL keep out_word and out_blank stable while out_valid && !out_ready.
REQ-024 SHALL clear out_valid after a handshake unless a new word loads in the same cycle (back-to-back allowed, one word per 4 cycles sustained).
REQ-025 SHALL treat flush with beat count 1..3 as follows: unfilled pixels SHALL be 0 and the word SHALL be emitted as if complete.
REQ-026 SHALL ignore flush when the beat count is 0 and no beat arrives.
REQ-027 SHALL treat flush together with an accepted beat as follows: the beat is included first, then the word is padded.
REQ-028 SHALL treat flush together with beat 3 exactly like plain beat 3.
REQ-029 SHALL hold flush pending while the output register is blocked and act on it once space frees; in_ready SHALL be low meanwhile.
REQ-030 SHALL increment word_cnt by 1 on each out_valid && out_ready and wrap modulo 2^CNT_W.

Reset
REQ-031 SHALL, on reset, set out_valid=0, out_word=0, out_blank=1, word_cnt=0, the beat counter to EMPTY, asm_full=0, the flush-pending flag=0 and the latched h=0.
REQ-032 SHALL discard any partial or held word when reset is asserted mid-word; in_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-033 SHALL pass this scenario: h=0, beats (pa,pb)=(1,2),(3,4),(5,6),(7,8), out_ready=1 -> out_word=32'h... computed by REQ-016, i.e. plane0 byte=8'h55, plane1=8'h66, plane2=8'h78, plane3=8'h80 -> 32'h80786655, out_valid 1 cycle after beat 3, word_cnt=1.
REQ-034 SHALL pass this scenario: the same beats with h=1 on beat 0 and h=0 on beats 1..3 -> each byte bit-reversed: 32'h011E66AA.
REQ-035 SHALL pass this scenario: out_ready=0, 8 beats offered -> in_ready drops after the 8th beat; out_word stays 32'h80786655; raising out_ready drains two words in order.
REQ-036 SHALL pass this scenario: beats (F,F),(F,F) then flush -> out_word=32'h0F0F0F0F, out_blank=0; all-zero beats plus flush -> out_blank=1.
REQ-037 SHALL pass this scenario: reset asserted after beat 2 -> no word emitted; the next 4 beats form a fresh word and word_cnt=1.
REQ-038 SHALL pass this scenario: word_cnt preset by 2^CNT_W-1 handoffs, plus one more -> word_cnt=0.
